// File: rtl/cache_mem_arbiter_pkg.sv
// cache_mem_arbiter_pkg: shared types and constants for the cache/memory arbiter
package cache_mem_arbiter_pkg;
    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
    typedef struct packed {
        logic        wr;
        logic [1:0]  size;
        logic [3:0]  wstrb;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_req_t;
    localparam logic [1:0] MEM_SIZE_BYTE = 2'd0;
    localparam logic [1:0] MEM_SIZE_HALF = 2'd1;
    localparam logic [1:0] MEM_SIZE_WORD = 2'd2;
    localparam logic OWNER_ICACHE = 1'b0;
    localparam logic OWNER_DCACHE = 1'b1;
    function automatic int line_w(input int offset_width);
        return 32 * (2 << offset_width);
    endfunction
endpackage

// File: rtl/cache_mem_arbiter_if.sv
// cache_mem_arbiter_if: memory-side request/response bus.
// master (arbiter) drives mem_req/wr/size/wstrb/addr/wdata;
// slave (memory bridge) drives mem_addrOK/mem_dataOK/mem_rdata.
interface cache_mem_arbiter_if
    import cache_mem_arbiter_pkg::*;
#(
    parameter int offset_width = 2
) ();
    logic                            mem_req;
    logic                            mem_wr;
    logic [1:0]                      mem_size;
    logic [3:0]                      mem_wstrb;
    logic [31:0]                     mem_addr;
    logic [31:0]                     mem_wdata;
    logic                            mem_addrOK;
    logic                            mem_dataOK;
    logic [line_w(offset_width)-1:0] mem_rdata;
    modport master (
        output mem_req, mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata,
        input  mem_addrOK, mem_dataOK, mem_rdata
    );
    modport slave (
        input  mem_req, mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata,
        output mem_addrOK, mem_dataOK, mem_rdata
    );
endinterface

// File: rtl/cache_mem_arbiter_rr2.sv
// mem_arb_rr2: two-input round-robin picker.
// req_i[0]=Icache, req_i[1]=Dcache; last_grant_i = previous winner;
// grant_o = winner index, valid_o = any request present.
module mem_arb_rr2 (
    input  logic [1:0] req_i,
    input  logic       last_grant_i,
    output logic       grant_o,
    output logic       valid_o
);
    assign valid_o = |req_i;
    assign grant_o = &req_i ? ~last_grant_i : req_i[1];
endmodule

// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter: shares one memory port between Icache refill and Dcache traffic.
// Cache side: icache_*/dcache_* requests in, owner-gated addrOK/dataOK and line data out.
// Memory side: mem (master modport) carries the registered request and the handshake.
// Status: arb_busy (transaction in flight), arb_owner (current/last owner, 1 = Dcache).
module cache_mem_arbiter
    import cache_mem_arbiter_pkg::*;
#(
    parameter int offset_width = 2
) (
    input  logic                            clk,
    input  logic                            rstn,
    input  logic                            icache_mem_req,
    input  logic [31:0]                     addr_icache_mem,
    output logic                            mem_icache_addrOK,
    output logic                            mem_icache_dataOK,
    output logic [line_w(offset_width)-1:0] din_mem_icache,
    input  logic                            dcache_mem_req,
    input  logic                            dcache_mem_wr,
    input  logic [1:0]                      dcache_mem_size,
    input  logic [3:0]                      dcache_mem_wstrb,
    input  logic [31:0]                     addr_dcache_mem,
    input  logic [31:0]                     dout_dcache_mem,
    output logic                            mem_dcache_addrOK,
    output logic                            mem_dcache_dataOK,
    output logic [line_w(offset_width)-1:0] din_mem_dcache,
    cache_mem_arbiter_if.master             mem,
    output logic                            arb_busy,
    output logic                            arb_owner
);
    state_t   state_q, state_d;
    mem_req_t req_q, req_d;
    logic     last_q, last_d;
    logic     grant, valid, take, addr_ok, data_ok;
    mem_arb_rr2 u_rr (
        .req_i        ({dcache_mem_req, icache_mem_req}),
        .last_grant_i (last_q),
        .grant_o      (grant),
        .valid_o      (valid)
    );
    // A new grant may be taken from IDLE or on the closing dataOK of DATA (no bubble).
    assign take = valid && (state_q == IDLE || (state_q == DATA && mem.mem_dataOK));
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            req_q   <= '0;
            last_q  <= OWNER_ICACHE;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            last_q  <= last_d;
        end
    end
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = valid ? ADDR : IDLE;
            ADDR:    if (mem.mem_addrOK) state_d = mem.mem_dataOK ? IDLE : DATA;
            DATA:    if (mem.mem_dataOK) state_d = valid ? ADDR : IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_comb begin
        req_d  = req_q;
        last_d = last_q;
        if (take) begin
            last_d = grant;
            req_d  = grant ? {dcache_mem_wr, dcache_mem_size, dcache_mem_wstrb, addr_dcache_mem, dout_dcache_mem}
                           : {1'b0, MEM_SIZE_WORD, 4'b0, addr_icache_mem, 32'b0};
        end
    end
    // Responses outside their legal state are dropped, never forwarded.
    always_comb begin
        addr_ok           = mem.mem_addrOK && state_q == ADDR;
        data_ok           = mem.mem_dataOK && (state_q == DATA || addr_ok);
        mem_icache_addrOK = addr_ok && last_q == OWNER_ICACHE;
        mem_dcache_addrOK = addr_ok && last_q == OWNER_DCACHE;
        mem_icache_dataOK = data_ok && last_q == OWNER_ICACHE;
        mem_dcache_dataOK = data_ok && last_q == OWNER_DCACHE;
    end
    assign mem.mem_req   = state_q == ADDR;
    assign mem.mem_wr    = req_q.wr;
    assign mem.mem_size  = req_q.size;
    assign mem.mem_wstrb = req_q.wstrb;
    assign mem.mem_addr  = req_q.addr;
    assign mem.mem_wdata = req_q.wdata;
    assign din_mem_icache = mem.mem_rdata;
    assign din_mem_dcache = mem.mem_rdata;
    assign arb_busy       = state_q != IDLE;
    assign arb_owner      = last_q;
endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb_cache_mem_arbiter: scoreboard bench; expected grants queued at stimulus, checked at the memory port.
module tb_cache_mem_arbiter;
    typedef struct packed {
        logic        owner;
        logic        wr;
        logic [1:0]  size;
        logic [3:0]  wstrb;
        logic [31:0] addr;
        logic [31:0] wdata;
    } exp_t;
    localparam logic [255:0] RD0 = {8{32'hA5A5A5A5}};
    localparam logic [255:0] RD1 = {4{64'h0123456789ABCDEF}};
    localparam logic [255:0] RD2 = {8{32'h5A00C3FF}};
    logic         clk = 0;
    logic         rstn;
    logic         icache_mem_req;
    logic [31:0]  addr_icache_mem;
    logic         mem_icache_addrOK, mem_icache_dataOK;
    logic [255:0] din_mem_icache;
    logic         dcache_mem_req, dcache_mem_wr;
    logic [1:0]   dcache_mem_size;
    logic [3:0]   dcache_mem_wstrb;
    logic [31:0]  addr_dcache_mem, dout_dcache_mem;
    logic         mem_dcache_addrOK, mem_dcache_dataOK;
    logic [255:0] din_mem_dcache;
    logic         arb_busy, arb_owner;
    int           n_chk = 0;
    int           n_fail = 0;
    exp_t         exp_q[$];
    cache_mem_arbiter_if #(.offset_width(2)) mem ();
    cache_mem_arbiter #(.offset_width(2)) dut (
        .clk               (clk),
        .rstn              (rstn),
        .icache_mem_req    (icache_mem_req),
        .addr_icache_mem   (addr_icache_mem),
        .mem_icache_addrOK (mem_icache_addrOK),
        .mem_icache_dataOK (mem_icache_dataOK),
        .din_mem_icache    (din_mem_icache),
        .dcache_mem_req    (dcache_mem_req),
        .dcache_mem_wr     (dcache_mem_wr),
        .dcache_mem_size   (dcache_mem_size),
        .dcache_mem_wstrb  (dcache_mem_wstrb),
        .addr_dcache_mem   (addr_dcache_mem),
        .dout_dcache_mem   (dout_dcache_mem),
        .mem_dcache_addrOK (mem_dcache_addrOK),
        .mem_dcache_dataOK (mem_dcache_dataOK),
        .din_mem_dcache    (din_mem_dcache),
        .mem               (mem),
        .arb_busy          (arb_busy),
        .arb_owner         (arb_owner)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask
    function automatic exp_t mk_i(input logic [31:0] a);
        return {1'b0, 1'b0, 2'd2, 4'b0, a, 32'b0};
    endfunction
    function automatic exp_t mk_d(input logic wr, input logic [1:0] sz, input logic [3:0] st,
                                  input logic [31:0] a, input logic [31:0] d);
        return {1'b1, wr, sz, st, a, d};
    endfunction
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic wait_req(input string tag);
        int t = 0;
        while (mem.mem_req !== 1'b1 && t < 50) begin
            tick();
            t++;
        end
        if (t >= 50) check(tag, mem.mem_req, 1'b1);
    endtask
    task automatic check_fields(input string tag, input exp_t e);
        check({tag, "_owner"}, arb_owner, e.owner);
        check({tag, "_wr"}, mem.mem_wr, e.wr);
        check({tag, "_size"}, mem.mem_size, e.size);
        check({tag, "_wstrb"}, mem.mem_wstrb, e.wstrb);
        check({tag, "_addr"}, mem.mem_addr, e.addr);
        check({tag, "_wdata"}, mem.mem_wdata, e.wdata);
    endtask
    // Memory responder: addrOK ad cycles into ADDR, dataOK dd cycles into DATA.
    task automatic serve(input int ad, input int dd, input logic [255:0] rd, input logic same, input logic spur);
        exp_t e;
        wait_req("req_timeout");
        if (mem.mem_req !== 1'b1) return;
        if (exp_q.size() == 0) begin
            check("sb_empty", exp_q.size(), 1);
            return;
        end
        e = exp_q.pop_front();
        check_fields("grant", e);
        repeat (ad) tick();
        check("req_held", mem.mem_req, 1'b1);
        check_fields("stable", e);
        mem.mem_addrOK = 1'b1;
        mem.mem_dataOK = same;
        mem.mem_rdata  = rd;
        @(negedge clk);
        check("addrok_own", e.owner ? mem_dcache_addrOK : mem_icache_addrOK, 1'b1);
        check("addrok_other", e.owner ? mem_icache_addrOK : mem_dcache_addrOK, 1'b0);
        if (same) begin
            check("same_dataok", e.owner ? mem_dcache_dataOK : mem_icache_dataOK, 1'b1);
            check("same_din", e.owner ? din_mem_dcache : din_mem_icache, rd);
        end
        tick();
        mem.mem_addrOK = 1'b0;
        mem.mem_dataOK = 1'b0;
        if (e.owner) dcache_mem_req = 1'b0;
        else icache_mem_req = 1'b0;
        if (same) return;
        check("req_drop", mem.mem_req, 1'b0);
        check("busy_data", arb_busy, 1'b1);
        if (spur) begin
            mem.mem_addrOK = 1'b1;
            @(negedge clk);
            check("spur_addrok", {mem_icache_addrOK, mem_dcache_addrOK}, 2'b00);
            tick();
            mem.mem_addrOK = 1'b0;
            check("spur_busy", arb_busy, 1'b1);
            check("spur_req", mem.mem_req, 1'b0);
        end
        repeat (dd) tick();
        mem.mem_dataOK = 1'b1;
        mem.mem_rdata  = rd;
        @(negedge clk);
        check("dataok_own", e.owner ? mem_dcache_dataOK : mem_icache_dataOK, 1'b1);
        check("dataok_other", e.owner ? mem_icache_dataOK : mem_dcache_dataOK, 1'b0);
        check("din", e.owner ? din_mem_dcache : din_mem_icache, rd);
        tick();
        mem.mem_dataOK = 1'b0;
    endtask
    task automatic set_d(input logic wr, input logic [1:0] sz, input logic [3:0] st,
                         input logic [31:0] a, input logic [31:0] d);
        dcache_mem_req   = 1'b1;
        dcache_mem_wr    = wr;
        dcache_mem_size  = sz;
        dcache_mem_wstrb = st;
        addr_dcache_mem  = a;
        dout_dcache_mem  = d;
        exp_q.push_back(mk_d(wr, sz, st, a, d));
    endtask
    task automatic set_i(input logic [31:0] a);
        icache_mem_req  = 1'b1;
        addr_icache_mem = a;
        exp_q.push_back(mk_i(a));
    endtask
    initial begin
        rstn = 1'b0;
        icache_mem_req = 0; addr_icache_mem = '0;
        dcache_mem_req = 0; dcache_mem_wr = 0; dcache_mem_size = '0; dcache_mem_wstrb = '0;
        addr_dcache_mem = '0; dout_dcache_mem = '0;
        mem.mem_addrOK = 0; mem.mem_dataOK = 0; mem.mem_rdata = '0;
        repeat (3) tick();
        check("rst_req", mem.mem_req, 1'b0);
        check("rst_busy", arb_busy, 1'b0);
        check("rst_owner", arb_owner, 1'b0);
        check("rst_fields", {mem.mem_wr, mem.mem_size, mem.mem_wstrb, mem.mem_addr, mem.mem_wdata}, '0);
        rstn = 1'b1;
        tick();
        // simultaneous requests: Dcache first, Icache back-to-back, then alternation again
        set_d(1'b0, 2'd2, 4'b0, 32'h0000_2000, 32'h0);
        set_i(32'h1C00_0080);
        serve(0, 0, RD2, 1'b0, 1'b0);
        check("b2b_busy", arb_busy, 1'b1);
        check("b2b_req", mem.mem_req, 1'b1);
        serve(1, 0, RD0, 1'b0, 1'b0);
        check("alt1_idle", arb_busy, 1'b0);
        set_d(1'b1, 2'd2, 4'b1111, 32'h0000_3008, 32'hDEAD_BEEF);
        set_i(32'h1C00_00C0);
        serve(0, 1, RD1, 1'b0, 1'b0);
        serve(0, 0, RD2, 1'b0, 1'b0);
        check("alt2_idle", arb_busy, 1'b0);
        // Icache alone
        set_i(32'h1C00_0040);
        serve(2, 2, RD0, 1'b0, 1'b0);
        check("ic_idle", arb_busy, 1'b0);
        // Dcache byte write
        set_d(1'b1, 2'd0, 4'b0010, 32'h0000_1004, 32'h0000_AB00);
        serve(3, 1, RD1, 1'b0, 1'b0);
        check("dw_idle", arb_busy, 1'b0);
        // addrOK and dataOK together in the first ADDR cycle
        set_i(32'h1C00_0100);
        serve(0, 0, RD1, 1'b1, 1'b0);
        check("same_idle", arb_busy, 1'b0);
        // spurious addrOK while in DATA
        set_d(1'b0, 2'd1, 4'b0, 32'h0000_4002, 32'h0);
        serve(0, 1, RD2, 1'b0, 1'b1);
        check("spur_idle", arb_busy, 1'b0);
        // spurious responses while IDLE
        mem.mem_addrOK = 1'b1;
        mem.mem_dataOK = 1'b1;
        @(negedge clk);
        check("idle_spur_ok", {mem_icache_addrOK, mem_icache_dataOK, mem_dcache_addrOK, mem_dcache_dataOK}, 4'b0);
        tick();
        mem.mem_addrOK = 1'b0;
        mem.mem_dataOK = 1'b0;
        check("idle_spur_busy", arb_busy, 1'b0);
        // reset asserted while in DATA, then a late dataOK
        dcache_mem_req = 1'b1; dcache_mem_wr = 1'b0; addr_dcache_mem = 32'h0000_5000;
        wait_req("rst_req_timeout");
        mem.mem_addrOK = 1'b1;
        tick();
        mem.mem_addrOK = 1'b0;
        dcache_mem_req = 1'b0;
        check("rstd_busy_pre", arb_busy, 1'b1);
        check("rstd_owner_pre", arb_owner, 1'b1);
        rstn = 1'b0;
        #1;
        check("rstd_busy", arb_busy, 1'b0);
        check("rstd_req", mem.mem_req, 1'b0);
        check("rstd_owner", arb_owner, 1'b0);
        mem.mem_dataOK = 1'b1;
        @(negedge clk);
        check("rstd_dataok", {mem_icache_dataOK, mem_dcache_dataOK}, 2'b00);
        tick();
        rstn = 1'b1;
        @(negedge clk);
        check("rstd_late_dataok", {mem_icache_dataOK, mem_dcache_dataOK}, 2'b00);
        check("rstd_late_busy", arb_busy, 1'b0);
        tick();
        mem.mem_dataOK = 1'b0;
        check("sb_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
